// File: rtl/switch_config_sequencer_if.sv
// Command and switch-interface bus of the switch configuration sequencer.
// slave = the sequencer itself, master = whoever feeds commands and
// models the six downstream switch interfaces.
interface switch_config_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd_data;
    logic [5:0]  sw_en;
    logic        sw_rst;
    logic [3:0]  sw_x;
    logic [2:0]  sw_y;
    logic        sw_on;
    logic [5:0]  sw_rdy;

    modport slave (
        input  cmd_valid, cmd_data, sw_rdy,
        output cmd_ready, sw_en, sw_rst, sw_x, sw_y, sw_on
    );

    modport master (
        output cmd_valid, cmd_data, sw_rdy,
        input  cmd_ready, sw_en, sw_rst, sw_x, sw_y, sw_on
    );
endinterface

// File: rtl/switch_config_sequencer.sv
// Switch configuration sequencer: queues 12-bit commands in an 8-deep FIFO
// and plays them out one at a time to six crosspoint switch interfaces,
// either as a single enable pulse with address/data or as a shared reset.
// Command word: [11] clear-all, [10:8] sw_id, [7:4] x, [3:1] y, [0] on.
module switch_config_sequencer (
    input  logic                            i_clk,
    input  logic                            i_rst,
    switch_config_sequencer_if.slave        bus,
    input  logic                            i_err_clr,
    output logic                            o_busy,
    output logic [3:0]                      o_fifo_count,
    output logic                            o_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_CLEAR, S_CLR_WAIT
    } state_t;

    state_t      r_state, w_next;

    logic [11:0] r_mem [8];
    logic [2:0]  r_wptr, r_rptr;
    logic [3:0]  r_count;
    logic [2:0]  r_id;
    logic [3:0]  r_x;
    logic [2:0]  r_y;
    logic        r_on;
    logic [7:0]  r_tmo;
    logic        r_err;

    logic        w_ready, w_push, w_pop, w_err_set, w_tmo_clr, w_tmo_hit;
    logic [11:0] w_head;
    logic [5:0]  w_id_oh;
    logic        w_rdy_sel;
    logic        w_waiting;

    assign w_ready   = (r_count < 4'd8);
    assign w_push    = bus.cmd_valid && w_ready;
    assign w_head    = r_mem[r_rptr];
    assign w_id_oh   = 6'b000001 << r_id;
    assign w_rdy_sel = |(bus.sw_rdy & w_id_oh);
    assign w_tmo_hit = (r_tmo == 8'd255);
    assign w_waiting = (r_state == S_WAIT_ACK) || (r_state == S_WAIT_DONE) ||
                       (r_state == S_CLR_WAIT);

    // FIFO storage; contents need no reset because the count gates reads
    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wptr] <= bus.cmd_data;
    end

    // FIFO pointers and occupancy; a simultaneous push and pop cancel out
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 3'd1;
            if (w_pop)  r_rptr <= r_rptr + 3'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic plus pop / error / timeout-clear strobes
    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
        w_tmo_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != 4'd0) begin
                    w_pop = 1'b1;
                    if (w_head[11])              w_next = S_CLEAR;
                    else if (w_head[10:8] <= 3'd5) w_next = S_ISSUE;
                    else                         w_err_set = 1'b1;
                end
            end
            S_ISSUE: begin
                w_next    = S_WAIT_ACK;
                w_tmo_clr = 1'b1;
            end
            S_WAIT_ACK: begin
                if (!w_rdy_sel) begin
                    w_next    = S_WAIT_DONE;
                    w_tmo_clr = 1'b1;
                end else if (w_tmo_hit) begin
                    w_err_set = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (w_rdy_sel) begin
                    w_next = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_err_set = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_CLEAR: begin
                w_next    = S_CLR_WAIT;
                w_tmo_clr = 1'b1;
            end
            S_CLR_WAIT: begin
                // r_tmo != 0 means this is at least the second cycle after CLEAR
                if ((&bus.sw_rdy) && (r_tmo != 8'd0)) begin
                    w_next = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_err_set = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Latch the popped command; held until the next pop
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_id <= '0;
            r_x  <= '0;
            r_y  <= '0;
            r_on <= 1'b0;
        end else if (w_pop) begin
            r_id <= w_head[10:8];
            r_x  <= w_head[7:4];
            r_y  <= w_head[3:1];
            r_on <= w_head[0];
        end
    end

    // Timeout counter: zero on entry to a wait state, counts while waiting
    always_ff @(posedge i_clk) begin
        if (i_rst || w_tmo_clr) r_tmo <= '0;
        else if (w_waiting)     r_tmo <= r_tmo + 8'd1;
    end

    // Sticky error; a new error wins over a same-cycle clear
    always_ff @(posedge i_clk) begin
        if (i_rst) r_err <= 1'b0;
        else       r_err <= (r_err & ~i_err_clr) | w_err_set;
    end

    assign bus.cmd_ready = w_ready;
    assign bus.sw_en     = (r_state == S_ISSUE) ? w_id_oh : 6'b000000;
    assign bus.sw_rst    = (r_state == S_CLEAR);
    assign bus.sw_x      = r_x;
    assign bus.sw_y      = r_y;
    assign bus.sw_on     = r_on;
    assign o_busy        = (r_state != S_IDLE) || (r_count != 4'd0);
    assign o_fifo_count  = r_count;
    assign o_err         = r_err;
endmodule

// File: tb/tb_switch_config_sequencer.sv
// Scoreboard bench for switch_config_sequencer: every accepted command is
// decoded into the pulse it should produce; a monitor matches pulses.
module tb_switch_config_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err_clr = 1'b0;
    logic       busy;
    logic [3:0] fifo_count;
    logic       err;

    switch_config_sequencer_if ifc();

    switch_config_sequencer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .bus          (ifc.slave),
        .i_err_clr    (err_clr),
        .o_busy       (busy),
        .o_fifo_count (fifo_count),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         clr;
        logic [5:0] en;
        logic [3:0] x;
        logic [2:0] y;
        logic       on;
    } exp_t;

    exp_t       exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         en_pulses = 0;
    int         rst_pulses = 0;
    bit         exp_err = 1'b0;
    bit         auto_mode = 1'b0;
    logic [5:0] rdy_auto = 6'b111111;
    logic [5:0] rdy_man  = 6'b111111;

    assign ifc.sw_rdy = auto_mode ? rdy_auto : rdy_man;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [11:0] mk(input bit clr, input int id, input int x, input int y, input bit on);
        return {clr, 3'(id), 4'(x), 3'(y), on};
    endfunction

    // Reference model: what an accepted command must eventually cause
    task automatic model_accept(input logic [11:0] d);
        exp_t e;
        e.clr = d[11];
        e.en  = 6'b000000;
        e.x   = d[7:4];
        e.y   = d[3:1];
        e.on  = d[0];
        if (d[11]) begin
            exp_q.push_back(e);
        end else if (int'(d[10:8]) < 6) begin
            e.en[d[10:8]] = 1'b1;
            exp_q.push_back(e);
        end else begin
            exp_err = 1'b1;
        end
    endtask

    // Called in the #1-after-edge phase; returns in that phase
    task automatic push_cmd(input logic [11:0] d);
        int g = 0;
        while (!ifc.cmd_ready && g < 3000) begin
            @(posedge clk); #1; g++;
        end
        check("cmd_ready_wait", 32'(ifc.cmd_ready), 32'd1);
        if (ifc.cmd_ready) begin
            ifc.cmd_valid = 1'b1;
            ifc.cmd_data  = d;
            @(posedge clk); #1;
            ifc.cmd_valid = 1'b0;
            model_accept(d);
        end
    endtask

    task automatic wait_en(input int max);
        int g = 0;
        while (ifc.sw_en == 6'd0 && g < max) begin
            @(posedge clk); #1; g++;
        end
        check("sw_en_seen", 32'(ifc.sw_en != 6'd0), 32'd1);
    endtask

    task automatic wait_rst(input int max);
        int g = 0;
        while (!ifc.sw_rst && g < max) begin
            @(posedge clk); #1; g++;
        end
        check("sw_rst_seen", 32'(ifc.sw_rst), 32'd1);
    endtask

    task automatic wait_idle(input int max);
        int g = 0;
        while ((busy || exp_q.size() != 0) && g < max) begin
            @(posedge clk); #1; g++;
        end
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every enable/reset pulse must match the next expected entry
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifc.sw_en != 6'd0 || ifc.sw_rst) begin
                check("one_pulse_bit", 32'($countones({ifc.sw_en, ifc.sw_rst})), 32'd1);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: sw_en=%b sw_rst=%b, nothing expected (t=%0t)",
                             ifc.sw_en, ifc.sw_rst, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_is_clear", 32'(ifc.sw_rst), 32'(e.clr));
                    if (ifc.sw_rst) begin
                        rst_pulses++;
                    end else begin
                        en_pulses++;
                        check("sw_en", 32'(ifc.sw_en), 32'(e.en));
                        check("sw_xyon", 32'({ifc.sw_x, ifc.sw_y, ifc.sw_on}),
                              32'({e.x, e.y, e.on}));
                    end
                end
            end
        end
    end

    // Switch-interface model: after an enable, drop ready then raise it
    initial begin
        int id, d1, d2;
        forever begin
            @(posedge clk); #1;
            if (auto_mode && ifc.sw_en != 6'd0) begin
                id = 0;
                for (int k = 0; k < 6; k++) if (ifc.sw_en[k]) id = k;
                d1 = $urandom_range(1, 4);
                d2 = $urandom_range(1, 10);
                repeat (d1) @(posedge clk);
                #1 rdy_auto[id] = 1'b0;
                repeat (d2) @(posedge clk);
                #1 rdy_auto[id] = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_data  = 12'h000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
        check("rst_outputs", 32'({ifc.sw_en, ifc.sw_rst, ifc.sw_x, ifc.sw_y, ifc.sw_on}), 32'd0);
        check("rst_err_busy", 32'({err, busy}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single command: id 2, x 5, y 3, on 1
        push_cmd(mk(0, 2, 5, 3, 1));
        wait_en(20);
        repeat (2) @(posedge clk);
        #1 rdy_man[2] = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            check("xyon_hold", 32'({ifc.sw_x, ifc.sw_y, ifc.sw_on}), 32'({4'd5, 3'd3, 1'b1}));
        end
        rdy_man[2] = 1'b1;
        wait_idle(20);
        check("single_en_pulses", 32'(en_pulses), 32'd1);

        // Bad switch id: error, no pulse, entry discarded
        push_cmd(mk(0, 7, 1, 1, 0));
        check("bad_id_queued", 32'(fifo_count), 32'd1);
        @(posedge clk); #1;
        check("bad_id_err", 32'(err), 32'(exp_err));
        check("bad_id_popped", 32'(fifo_count), 32'd0);
        repeat (3) @(posedge clk);
        #1 check("bad_id_no_pulse", 32'(en_pulses), 32'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        exp_err = 1'b0;
        check("err_clr", 32'(err), 32'(exp_err));

        // Fill FIFO while stalled in WAIT_ACK (ready never drops)
        push_cmd(mk(0, 1, 9, 2, 1));
        wait_en(20);
        for (int i = 0; i < 8; i++)
            push_cmd(mk(0, i % 6, $urandom_range(0, 15), $urandom_range(0, 7), 1'($urandom)));
        check("full_cmd_ready", 32'(ifc.cmd_ready), 32'd0);
        check("full_count", 32'(fifo_count), 32'd8);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_data  = mk(0, 4, 4, 4, 0);
        @(posedge clk); #1;
        ifc.cmd_valid = 1'b0;
        check("full_push_ignored", 32'(fifo_count), 32'd8);
        rdy_man[1] = 1'b0;
        @(posedge clk); #1;
        rdy_man[1] = 1'b1;
        auto_mode  = 1'b1;
        push_cmd(mk(0, 4, 4, 4, 0));
        wait_idle(3000);
        check("fill_err_clean", 32'(err), 32'(exp_err));

        // Clear-all with all ready high: leaves CLR_WAIT on the 2nd cycle
        push_cmd(mk(1, 0, 0, 0, 0));
        wait_rst(20);
        @(posedge clk); #1;
        check("clr_wait_c1_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("clr_wait_c2_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("clr_done_busy", 32'(busy), 32'd0);

        // Clear-all with ready held low: times out 256 cycles after entry
        auto_mode = 1'b0;
        rdy_man   = 6'b000000;
        p = rst_pulses;
        push_cmd(mk(1, 0, 0, 0, 0));
        wait_rst(20);
        @(posedge clk);           // CLR_WAIT entry edge
        repeat (255) @(posedge clk);
        #1 check("tmo_err_before", 32'(err), 32'd0);
        @(posedge clk); #1;
        check("tmo_err_at_256", 32'(err), 32'd1);
        check("tmo_back_idle", 32'(busy), 32'd0);
        repeat (40) @(posedge clk);
        #1 check("tmo_no_retry", 32'(rst_pulses - p), 32'd1);
        rdy_man = 6'b111111;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("tmo_err_clr", 32'(err), 32'd0);

        // Randomized stream against the model
        auto_mode = 1'b1;
        exp_err   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 15);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            if (r == 0)      push_cmd(mk(1, 0, $urandom_range(0, 15), 0, 0));
            else if (r == 1) push_cmd(mk(0, $urandom_range(6, 7), 3, 3, 1));
            else             push_cmd(mk(0, $urandom_range(0, 5), $urandom_range(0, 15),
                                         $urandom_range(0, 7), 1'($urandom)));
        end
        wait_idle(5000);
        check("rand_err", 32'(err), 32'(exp_err));
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;

        // Reset in WAIT_DONE with 3 entries queued
        auto_mode = 1'b0;
        rdy_man   = 6'b111111;
        push_cmd(mk(0, 3, 12, 6, 1));
        wait_en(20);
        rdy_man[3] = 1'b0;
        @(posedge clk); #1;
        push_cmd(mk(0, 0, 1, 1, 1));
        push_cmd(mk(0, 5, 2, 2, 0));
        push_cmd(mk(0, 1, 3, 3, 1));
        check("pre_rst_count", 32'(fifo_count), 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_outputs", 32'({ifc.sw_en, ifc.sw_rst, ifc.sw_x, ifc.sw_y, ifc.sw_on}), 32'd0);
        check("mid_rst_flags", 32'({err, busy, ifc.cmd_ready}), 32'b001);
        rst = 1'b0;
        exp_q.delete();
        p = en_pulses;
        rdy_man = 6'b111111;
        repeat (40) @(posedge clk);
        #1;
        check("post_rst_no_pulse", 32'(en_pulses - p), 32'd0);
        check("post_rst_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
